regfile_write_checker: RTL
==========================

# regfile_write_checker

Self-checking monitor that sits directly downstream of the processor's register-file write port in the simple-processor skeleton. It holds an expected-value list loaded before a run, observes every committed register write, compares each non-`$r0` write in order against the list, and reports pass/fail, an error count and the first mismatch. It lets the directed register-readback check run in fabric and on the bench from a single shared block.

## Interface
Parameters:
- `NUM_CHECKS`, 13: number of expected writes per run; legal range 1..16.
- `TIMEOUT`, 64: cycles allowed between consecutive qualifying writes before the run aborts; legal range 2..255.
- `IDX_W`, 4: width of index ports; must satisfy 2^IDX_W >= NUM_CHECKS.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `ctrl_reset`  in  1  synchronous, active-low reset (0 = reset), sampled on `clock` rising edge.
- `exp_we`  in  1  write strobe for the expected-value memory.
- `exp_addr`  in  IDX_W  expected-value memory address.
- `exp_data`  in  32  expected value to store.
- `start`  in  1  single-cycle pulse that begins a run.
- `ctrl_writeEnable`  in  1  register-file write enable from the processor.
- `ctrl_writeReg`  in  5  destination register of the write.
- `data_writeReg`  in  32  data being written.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done` AND `error_count`==0 AND NOT `timeout`.
- `timeout`  out  1  run ended by inactivity.
- `error_count`  out  8  mismatches this run, saturating at 255.
- `check_index`  out  IDX_W  index of the next expected value.
- `first_err_index`  out  IDX_W  index of first mismatch.
- `first_err_data`  out  32  observed data of first mismatch.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Qualifying write: `ctrl_writeEnable`=1 and `ctrl_writeReg`!=0. Writes to `$r0` are ignored in every state.
- IDLE:
  - `exp_we`=1 writes `exp_data` to `mem[exp_addr]`. Addresses >= NUM_CHECKS are dropped.
  - `start`=1 moves to RUN, and clears `check_index`, `error_count`, `timeout`, first-error regs and the inactivity timer.
  - If `exp_we` and `start` are high in the same cycle, the write completes and the run starts.
- RUN:
  - Each qualifying write compares `data_writeReg` with `mem[check_index]`, then increments `check_index`.
  - On mismatch, `error_count` increments (saturating at 255). On the first mismatch only, capture `check_index` and `data_writeReg` into the first-error registers.
  - When the qualifying write at index NUM_CHECKS-1 completes, move to DONE.
  - The inactivity timer increments each cycle without a qualifying write and clears on one. When it reaches TIMEOUT-1 with no qualifying write, set `timeout`=1 and move to DONE. `error_count` is not adjusted for unchecked entries.
  - `start` and `exp_we` are ignored.
- DONE:
  - All status outputs hold. Writes are ignored.
  - `start` restarts as from IDLE. `exp_we` is accepted, as in IDLE.
- Expected-value memory is not cleared by reset; contents are retained.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `timeout`=0, `error_count`=0, `check_index`=0, `first_err_index`=0, `first_err_data`=0.
- `busy` rises the cycle after `start` is sampled. A qualifying write in that same `start` cycle is not checked.
- Compare latency is 1 cycle. `error_count`, `check_index` and first-error outputs reflect a write on the edge that samples it.
- `done` rises on the edge sampling the last qualifying write; `busy` falls on the same edge.
- For a timeout, `done` and `timeout` rise exactly TIMEOUT cycles after the last qualifying write, or after RUN entry if there were none.
- `ctrl_reset`=0 mid-run aborts to IDLE on that edge. Outputs take reset values and the next `start` is required.
- Back-to-back qualifying writes every cycle are supported with no stalls.

## Test plan
- Load 13 values {5,3,8,2,0,1,3,20,4,345,567,345,567}, pulse `start`, then drive matching writes to r1..r13 one every 2 cycles -> `done`=1, `pass`=1, `error_count`=0, `check_index`=13.
- Same load, but write 9 instead of 8 at index 2 and 0 instead of 567 at index 12 -> `error_count`=2, `first_err_index`=2, `first_err_data`=9, `pass`=0.
- Interleave `$r0` writes of 0xDEADBEEF between correct writes -> ignored; `pass`=1 after exactly 13 qualifying writes.
- TIMEOUT=8: after 5 correct writes, stop writing -> `timeout`=1 and `done`=1 exactly 8 cycles after the 5th write; `check_index`=5, `pass`=0.
- Drive `ctrl_reset`=0 for one cycle after the 6th write -> all outputs 0, IDLE. Restart with no reload and 13 correct writes -> `pass`=1, confirming memory retention.
- Pulse `start` while `busy`=1, and drive `exp_we` to addr 3 mid-run -> neither has any effect; the run completes against the original values.

Source files
------------

// File: rtl/regfile_write_checker.sv
// rtl/regfile_write_checker.sv - register-file write-port monitor checking committed writes against an expected list
// Observes non-$r0 writes in order, compares them with a preloaded list, and reports pass/fail and the first mismatch.
module regfile_write_checker #(
  parameter int NUM_CHECKS = 13,
  parameter int TIMEOUT    = 64,
  parameter int IDX_W      = 4
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_addr,
  input  logic [31:0]      exp_data,
  input  logic             start,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [31:0]      data_writeReg,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [7:0]       error_count,
  output logic [IDX_W-1:0] check_index,
  output logic [IDX_W-1:0] first_err_index,
  output logic [31:0]      first_err_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
  localparam logic [7:0]       TMO_LIM  = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] fe_idx_q, fe_idx_d;
  logic [31:0]      fe_data_q, fe_data_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       timer_q, timer_d;
  logic [31:0]      mem_q [NUM_CHECKS];
  logic             mem_we;
  logic             qual;

  assign qual = ctrl_writeEnable && (ctrl_writeReg != 5'd0);

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    idx_d     = idx_q;
    fe_idx_d  = fe_idx_q;
    fe_data_d = fe_data_q;
    tmo_d     = tmo_q;
    timer_d   = timer_q;
    mem_we    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (qual) begin
          timer_d = 8'd0;
          idx_d   = idx_q + 1'b1;
          if (data_writeReg != mem_q[idx_q]) begin
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            // error_count saturates, so zero means no mismatch seen yet this run
            if (err_cnt_q == 8'd0) begin
              fe_idx_d  = idx_q;
              fe_data_d = data_writeReg;
            end
          end
          if (idx_q == LAST_IDX) state_d = S_DONE;
        end else if (timer_q == TMO_LIM) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        mem_we = exp_we && (exp_addr <= LAST_IDX);
        if (start) begin
          state_d   = S_RUN;
          err_cnt_d = 8'd0;
          idx_d     = '0;
          fe_idx_d  = '0;
          fe_data_d = 32'd0;
          tmo_d     = 1'b0;
          timer_d   = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q   <= S_IDLE;
      err_cnt_q <= 8'd0;
      idx_q     <= '0;
      fe_idx_q  <= '0;
      fe_data_q <= 32'd0;
      tmo_q     <= 1'b0;
      timer_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      idx_q     <= idx_d;
      fe_idx_q  <= fe_idx_d;
      fe_data_q <= fe_data_d;
      tmo_q     <= tmo_d;
      timer_q   <= timer_d;
    end
  end

  // Expected values survive reset so a run can be repeated without reloading.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[exp_addr] <= exp_data;
  end

  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_cnt_q == 8'd0) && !tmo_q;
  assign timeout         = tmo_q;
  assign error_count     = err_cnt_q;
  assign check_index     = idx_q;
  assign first_err_index = fe_idx_q;
  assign first_err_data  = fe_data_q;

endmodule
